fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
IF stage of the rv32im pipeline: PC register, instruction-memory request handshake, and the IF/ID pipeline register. Consumes `stall` from hazard_detection_unit and freezes IF/ID while it is asserted. Consumes `flush`/`redirect_pc` from EX for taken branches and jumps. Feeds the decode stage and the hazard unit's ID_rs1/ID_rs2 path via IF_ID_instr.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction presented on IF_ID_instr when IF_ID_valid=0 (addi x0,x0,0).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
stall  input  1  from hazard_detection_unit; hold PC and IF/ID.
flush  input  1  from EX; taken branch/jump, redirect fetch.
redirect_pc  input  32  target PC, sampled when flush=1.
imem_req  output  1  instruction fetch request.
imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ready=0.
imem_ready  input  1  memory has returned imem_rdata this cycle (may be same cycle as req).
imem_rdata  input  32  fetched instruction, valid when imem_req && imem_ready.
IF_ID_pc  output  32  PC of instruction in IF/ID.
IF_ID_instr  output  32  instruction in IF/ID.
IF_ID_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=FETCH, buffer empty, IF_ID_pc=0, IF_ID_instr=NOP_INSTR, IF_ID_valid=0. imem_req=0 while rst=1. First request is in the first cycle after release.
- Transaction completes in a cycle where imem_req && imem_ready ("accept"). No new address is issued until the outstanding one is accepted.
- FETCH state: imem_req=1, imem_addr=pc.
  - Accept && !stall && !flush: IF/ID <= {pc, imem_rdata, 1}; pc <= pc+4. Stay in FETCH. Back-to-back fetches give one instruction per cycle when ready is combinational.
  - Accept && stall && !flush: buf <= {pc, imem_rdata}; pc <= pc+4; IF/ID holds. Go to HOLD.
  - No accept && !stall && !flush: IF_ID_valid <= 0 and IF_ID_instr <= NOP_INSTR (bubble).
  - No accept && stall: IF/ID holds.
- HOLD state: imem_req=0. IF/ID holds while stall=1. On first cycle with stall=0: IF/ID <= {buf_pc, buf_instr, 1}, buffer cleared, go to FETCH.
- DROP state: imem_req=1, imem_addr=drop_addr, the stale address latched at flush. The response is discarded on accept, then go to FETCH. IF_ID_valid stays 0 throughout.
- Flush has highest priority over stall, accept and HOLD:
  - pc <= redirect_pc; IF_ID_valid <= 0; IF_ID_instr <= NOP_INSTR; buffer cleared.
  - From FETCH with no accept in the same cycle: drop_addr <= current pc, go to DROP.
  - From FETCH with accept in the same cycle, from HOLD, or from DROP with accept: go to FETCH.
  - Flush in DROP without accept: stay in DROP, keep drop_addr, update pc.
- When IF_ID_valid=0, IF_ID_pc holds its last value (don't-care to consumers).
- PC arithmetic is 32-bit wrap-around: 32'hFFFF_FFFC+4 = 0. redirect_pc[1:0] is forced to 2'b00.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments each cycle with stall=1.
  - flush_count increments each cycle with flush=1.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset release, imem_ready tied 1, rdata = addr|1: imem_addr sequence 0,4,8. IF_ID_pc 0,4,8 on consecutive cycles, IF_ID_valid=1 from cycle 2.
2. stall=1 for 3 cycles during steady fetch at pc=8: one accept buffered (pc=8). IF/ID holds pc=4 for 3 cycles, imem_req=0 in HOLD. After release IF_ID_pc=8, then 12.
3. flush with redirect_pc=32'h100 at pc=12, imem_ready=1: next imem_addr=32'h100. IF_ID_valid=0 for one cycle, then IF_ID_pc=32'h100.
4. imem_ready=0 at address 16, flush to 32'h200, ready returns 2 cycles later: imem_addr stays 16 until accept. Data discarded, IF_ID_valid=0. Next request at 32'h200.
5. flush and stall asserted together in HOLD: buffer dropped, pc=redirect_pc, IF_ID_valid=0, FETCH resumes at the target.
6. rst asserted while in DROP: outputs return to reset values immediately. Fetch restarts at RESET_PC after release. With FETCH_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction-memory request handshake and IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush event counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic [31:0] buf_pc;
    logic [31:0] buf_instr;
    logic        buf_vld;
    logic        accept;
    logic [31:0] redirect_aligned;

    assign imem_req         = ~rst & (state != S_HOLD);
    assign imem_addr        = (state == S_DROP) ? drop_addr : pc;
    assign accept           = imem_req & imem_ready;
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    // Control path: state, PC and IF/ID register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            buf_vld     <= 1'b0;
            IF_ID_pc    <= 32'h0000_0000;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else if (flush) begin
            pc          <= redirect_aligned;
            buf_vld     <= 1'b0;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
            // An unaccepted request must still be retired before the new target is issued.
            if (state != S_HOLD && !accept)
                state <= S_DROP;
            else
                state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (accept) begin
                        pc <= pc + 32'd4;
                        if (stall) begin
                            buf_vld <= 1'b1;
                            state   <= S_HOLD;
                        end else begin
                            IF_ID_pc    <= pc;
                            IF_ID_instr <= imem_rdata;
                            IF_ID_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        IF_ID_instr <= NOP_INSTR;
                        IF_ID_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        IF_ID_pc    <= buf_pc;
                        IF_ID_instr <= buf_vld ? buf_instr : NOP_INSTR;
                        IF_ID_valid <= buf_vld;
                        buf_vld     <= 1'b0;
                        state       <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (accept)
                        state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Data path: skid buffer and stale-address latch, qualified by control
    always_ff @(posedge clk) begin
        if (!flush && state == S_FETCH && accept && stall) begin
            buf_pc    <= pc;
            buf_instr <= imem_rdata;
        end
        if (flush && state == S_FETCH && !accept)
            drop_addr <= pc;
    end

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'h0000_0000;
            flush_count  <= 32'h0000_0000;
        end else begin
            if (stall)
                stall_cycles <= sat_inc(stall_cycles);
            if (flush)
                flush_count <= sat_inc(flush_count);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; memory returns addr|1 as the instruction.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int checks = 0;
    int failures = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        ready;
        logic [31:0] redirect;
        logic        exp_req;
        logic        chk_addr;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic        chk_pc;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[20];

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .IF_ID_pc(IF_ID_pc),
        .IF_ID_instr(IF_ID_instr),
        .IF_ID_valid(IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr | 32'h1;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        stall       = v.stall;
        flush       = v.flush;
        redirect_pc = v.redirect;
        imem_ready  = v.ready;
        #1;
        check("imem_req", idx, {31'b0, imem_req}, {31'b0, v.exp_req});
        if (v.chk_addr)
            check("imem_addr", idx, imem_addr, v.exp_addr);
        @(posedge clk);
        if (v.stall) exp_stall++;
        if (v.flush) exp_flush++;
        #1;
        check("IF_ID_valid", idx, {31'b0, IF_ID_valid}, {31'b0, v.exp_valid});
        check("IF_ID_instr", idx, IF_ID_instr, v.exp_instr);
        if (v.chk_pc)
            check("IF_ID_pc", idx, IF_ID_pc, v.exp_pc);
    endtask

    task automatic check_reset_outputs(input int idx);
        check("rst_imem_req", idx, {31'b0, imem_req}, 32'h0);
        check("rst_IF_ID_valid", idx, {31'b0, IF_ID_valid}, 32'h0);
        check("rst_IF_ID_instr", idx, IF_ID_instr, NOP);
        check("rst_IF_ID_pc", idx, IF_ID_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_stall_cycles", idx, stall_cycles, 32'h0);
        check("rst_flush_count", idx, flush_count, 32'h0);
`endif
    endtask

    initial begin
        //            stall flush rdy redirect        req chkA addr           vld chkP pc             instr
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0,         32'h1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h4,         1'b1, 1'b1, 32'h4,         32'h5};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h8,         1'b1, 1'b1, 32'h4,         32'h5};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h5};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h5};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'h9};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h100,       1'b1, 1'b1, 32'hC,         1'b0, 1'b0, 32'h0,         NOP};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h100,       1'b1, 1'b1, 32'h100,       32'h101};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h13,        1'b1, 1'b1, 32'h104,       1'b0, 1'b0, 32'h0,         NOP};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        1'b0, 1'b0, 32'h0,         NOP};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h200,       1'b1, 1'b1, 32'h10,        1'b0, 1'b0, 32'h0,         NOP};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        1'b0, 1'b0, 32'h0,         NOP};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h10,        1'b0, 1'b0, 32'h0,         NOP};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h200,       1'b1, 1'b1, 32'h200,       32'h201};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h204,       1'b0, 1'b0, 32'h0,         NOP};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFD};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0,         32'h1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b0, 1'b0, 32'h0,         NOP};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h4,         1'b1, 1'b1, 32'h4,         32'h5};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b1, 1'b1, 32'h4,         32'h5};

        // Reset state while rst is held
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(-1);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first_req_after_release", -1, {31'b0, imem_req}, 32'h1);
        check("first_addr_after_release", -1, imem_addr, 32'h0);

        for (int i = 0; i < 20; i++)
            apply(i, vecs[i]);

        // Flush together with stall while in HOLD: buffered pc=8 must be dropped
        apply(100, '{1'b1, 1'b0, 1'b1, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 1'b1, 32'h4,   32'h5});
        apply(101, '{1'b1, 1'b1, 1'b0, 32'h300, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   NOP});
        apply(102, '{1'b0, 1'b0, 1'b1, 32'h0,   1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 32'h300, 32'h301});

        // Enter DROP, then assert reset asynchronously mid-cycle
        apply(200, '{1'b0, 1'b1, 1'b0, 32'h400, 1'b1, 1'b1, 32'h304, 1'b0, 1'b0, 32'h0,   NOP});
        apply(201, '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h304, 1'b0, 1'b0, 32'h0,   NOP});
`ifdef FETCH_PERF_CNT_EN
        check("stall_cycles", 201, stall_cycles, exp_stall);
        check("flush_count", 201, flush_count, exp_flush);
`endif
        @(negedge clk);
        stall      = 1'b0;
        flush      = 1'b0;
        imem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(202);
        @(posedge clk);
        #1;
        check_reset_outputs(203);
        @(negedge clk);
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        apply(204, '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 32'h1});
        apply(205, '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 32'h4, 32'h5});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
